// File: rtl/reduce_stream.sv
// ============================================================================
//  Module      : reduce_stream
//  Description : Reduces a frame of WORDS consecutive WIDTH-bit words, taken
//                over a valid/ready input, into one AND, OR and XOR bit over
//                every bit of the frame. The result is registered and held on
//                a valid/ready output until the consumer accepts it.
//                Optional macro REDUCE_STREAM_POPCNT_EN adds a ones-count
//                accumulator and the pop_o result port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reduce_stream #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             and_o,
    output logic             or_o,
`ifdef REDUCE_STREAM_POPCNT_EN
    output logic             xor_o,
    output logic [$clog2(WIDTH*WORDS+1)-1:0] pop_o
`else
    output logic             xor_o
`endif
);

    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [0:0] S_ACC  = 1'b0;
    localparam logic [0:0] S_DONE = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic             r_and_acc;
    logic             r_or_acc;
    logic             r_xor_acc;
    logic             r_and_o;
    logic             r_or_o;
    logic             r_xor_o;

    logic             w_accept;
    logic             w_last;
    logic             w_handshake;
    logic             w_and_nxt;
    logic             w_or_nxt;
    logic             w_xor_nxt;

    // Input is only open while no result is pending
    assign in_ready    = ~r_out_valid;
    assign w_accept    = in_valid & ~r_out_valid;
    assign w_last      = w_accept && (r_cnt == CNT_W'(WORDS - 1));
    assign w_handshake = (r_state == S_DONE) && out_ready;

    // Running reductions including the beat currently on din
    assign w_and_nxt = r_and_acc & (&din);
    assign w_or_nxt  = r_or_acc  | (|din);
    assign w_xor_nxt = r_xor_acc ^ (^din);

    // Frame sequencing: beat counter, state and result-valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_ACC;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_state     <= S_ACC;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_last) begin
            r_state     <= S_DONE;
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
        end else if (w_accept) begin
            r_cnt       <= r_cnt + CNT_W'(1);
        end else if (w_handshake) begin
            r_state     <= S_ACC;
            r_out_valid <= 1'b0;
        end
    end

    // Bit-reduction accumulators, reseeded at frame end or abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_and_acc <= 1'b1;
            r_or_acc  <= 1'b0;
            r_xor_acc <= 1'b0;
        end else if (clear || w_last) begin
            r_and_acc <= 1'b1;
            r_or_acc  <= 1'b0;
            r_xor_acc <= 1'b0;
        end else if (w_accept) begin
            r_and_acc <= w_and_nxt;
            r_or_acc  <= w_or_nxt;
            r_xor_acc <= w_xor_nxt;
        end
    end

    // Result registers load only on the last beat and otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_and_o <= 1'b0;
            r_or_o  <= 1'b0;
            r_xor_o <= 1'b0;
        end else if (!clear && w_last) begin
            r_and_o <= w_and_nxt;
            r_or_o  <= w_or_nxt;
            r_xor_o <= w_xor_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign and_o     = r_and_o;
    assign or_o      = r_or_o;
    assign xor_o     = r_xor_o;

`ifdef REDUCE_STREAM_POPCNT_EN
    // Accumulator is wide enough for an all-ones frame, so no wrap can occur
    localparam int POP_W = $clog2(WIDTH*WORDS+1);

    logic [POP_W-1:0] r_pop_acc;
    logic [POP_W-1:0] r_pop_o;
    logic [POP_W-1:0] w_din_pop;
    logic [POP_W-1:0] w_pop_nxt;

    // Ones count of the word on din
    always_comb begin
        w_din_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_din_pop = w_din_pop + POP_W'(din[i]);
        end
    end

    assign w_pop_nxt = r_pop_acc + w_din_pop;

    // Ones-count accumulator, same reseed rules as the bit reductions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop_acc <= '0;
        end else if (clear || w_last) begin
            r_pop_acc <= '0;
        end else if (w_accept) begin
            r_pop_acc <= w_pop_nxt;
        end
    end

    // Ones-count result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop_o <= '0;
        end else if (!clear && w_last) begin
            r_pop_o <= w_pop_nxt;
        end
    end

    assign pop_o = r_pop_o;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reduce_stream.sv
// ============================================================================
//  Module      : tb_reduce_stream
//  Description : Self-checking bench for reduce_stream. A frame-level model
//                (queue of accepted words, pending-result flag) predicts every
//                output; directed cases plus randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reduce_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // DUT 0: WIDTH=4, WORDS=4
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] din = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       and_o, or_o, xor_o;

    // DUT 1: WIDTH=8, WORDS=1
    logic       clear1 = 1'b0;
    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic [7:0] din1 = '0;
    logic       out_valid1;
    logic       out_ready1 = 1'b0;
    logic       and1, or1, xor1;

`ifdef REDUCE_STREAM_POPCNT_EN
    logic [4:0] pop_o;
    logic [3:0] pop1;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // Model state
    logic [3:0] q[$];
    bit         e_valid = 0;
    bit         e_and, e_or, e_xor;
    int         e_pop;

    always #5 clk = ~clk;

    reduce_stream #(.WIDTH(4), .WORDS(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready),
        .and_o(and_o), .or_o(or_o),
`ifdef REDUCE_STREAM_POPCNT_EN
        .xor_o(xor_o), .pop_o(pop_o)
`else
        .xor_o(xor_o)
`endif
    );

    reduce_stream #(.WIDTH(8), .WORDS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear1),
        .in_valid(in_valid1), .in_ready(in_ready1), .din(din1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .and_o(and1), .or_o(or1),
`ifdef REDUCE_STREAM_POPCNT_EN
        .xor_o(xor1), .pop_o(pop1)
`else
        .xor_o(xor1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Compare DUT 0 against the model's view of the current cycle
    task automatic check_model();
        chk("out_valid", out_valid, e_valid);
        chk("in_ready", in_ready, !e_valid);
        if (e_valid) begin
            chk("and", and_o, e_and);
            chk("or", or_o, e_or);
            chk("xor", xor_o, e_xor);
`ifdef REDUCE_STREAM_POPCNT_EN
            chk("pop", pop_o, e_pop);
`endif
        end
    endtask

    // Advance the model by one clock edge using the inputs now applied
    task automatic model_edge();
        int ones;
        if (clear) begin
            q.delete();
            e_valid = 0;
        end else if (in_valid && !e_valid) begin
            q.push_back(din);
            if (q.size() == 4) begin
                ones = 0;
                foreach (q[i]) ones += $countones(q[i]);
                e_pop   = ones;
                e_and   = (ones == 16);
                e_or    = (ones != 0);
                e_xor   = ones[0];
                e_valid = 1;
                q.delete();
            end
        end else if (e_valid && out_ready) begin
            e_valid = 0;
        end
    endtask

    // One cycle: entered at posedge+1, leaves at next posedge+1
    task automatic cyc(input bit v, input logic [3:0] d, input bit r, input bit c);
        in_valid  = v;
        din       = d;
        out_ready = r;
        clear     = c;
        @(negedge clk);
        check_model();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_and", and_o, 0);
        chk("rst_or", or_o, 0);
        chk("rst_xor", xor_o, 0);
`ifdef REDUCE_STREAM_POPCNT_EN
        chk("rst_pop", pop_o, 0);
`endif
        q.delete();
        e_valid = 0;
        in_valid = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
    endtask

    task automatic chk_res(input string tag, input bit a, input bit o, input bit x, input int p);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_and"}, and_o, a);
        chk({tag, "_or"}, or_o, o);
        chk({tag, "_xor"}, xor_o, x);
`ifdef REDUCE_STREAM_POPCNT_EN
        chk({tag, "_pop"}, pop_o, p);
`else
        if (p < 0) $display("unexpected negative count");
`endif
    endtask

    task automatic single_word(input logic [7:0] d);
        int ones;
        ones = $countones(d);
        in_valid1  = 1'b1;
        din1       = d;
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        chk("w1_valid", out_valid1, 1);
        chk("w1_in_ready", in_ready1, 0);
        chk("w1_and", and1, ones == 8);
        chk("w1_or", or1, ones != 0);
        chk("w1_xor", xor1, ones % 2);
`ifdef REDUCE_STREAM_POPCNT_EN
        chk("w1_pop", pop1, ones);
`endif
        @(posedge clk);
        #1;
        chk("w1_drained", out_valid1, 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_and", and_o, 0);
        chk("reset_or", or_o, 0);
        chk("reset_xor", xor_o, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);

        // All-ones frame, consumer always ready
        repeat (4) cyc(1, 4'hF, 1, 0);
        chk_res("ones", 1, 1, 0, 16);
        cyc(1, 4'h1, 1, 0);              // handshake cycle: beat refused
        chk("bubble_in_ready", in_ready, 1);

        // Single set bit
        cyc(1, 4'h1, 1, 0);
        repeat (3) cyc(1, 4'h0, 1, 0);
        chk_res("onebit", 0, 1, 1, 1);
        cyc(0, 4'h0, 1, 0);

        // Back-pressure hold
        repeat (4) cyc(1, 4'h7, 0, 0);
        repeat (5) cyc(1, 4'hF, 0, 0);
        chk_res("hold", 0, 1, 0, 12);
        cyc(0, 4'h0, 1, 0);
        chk("hold_released", out_valid, 0);
        chk("hold_in_ready", in_ready, 1);

        // Clear aborts a frame and drops the concurrent beat
        repeat (2) cyc(1, 4'hF, 1, 0);
        cyc(1, 4'hF, 1, 1);
        chk("clear_no_result", out_valid, 0);
        repeat (4) cyc(1, 4'h0, 1, 0);
        chk_res("clear", 0, 0, 0, 0);
        cyc(0, 4'h0, 1, 0);

        // Asynchronous reset mid-frame, then in DONE
        repeat (3) cyc(1, 4'hF, 1, 0);
        async_reset();
        cyc(1, 4'h3, 0, 0);
        cyc(1, 4'h3, 0, 0);
        cyc(1, 4'h3, 0, 0);
        cyc(1, 4'h2, 0, 0);
        chk_res("fresh", 0, 1, 1, 7);
        async_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) != 0, 4'($urandom),
                $urandom_range(0, 4) < 3, $urandom_range(0, 31) == 0);
        cyc(0, 4'h0, 1, 0);

        // WORDS=1, WIDTH=8 instance
        single_word(8'hA5);
        chk("after_w1_quiet", out_valid, 0);
        single_word(8'hFF);
        single_word(8'h00);
        single_word(8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reduce_stream.md
# reduce_stream

Parametrised, sequential successor to the team's 4-bit combinational reduction gates. It reduces a frame of `WORDS` consecutive input words, each `WIDTH` bits wide, to a single AND, OR and XOR bit over every bit in the frame. It sits between a valid/ready word source and a valid/ready result consumer. It registers and holds its result until the consumer accepts it.

## Interface
- `WIDTH`, default 4: bits per input word, ≥1.
- `WORDS`, default 4: beats per frame, ≥1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous frame abort.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: block accepts a word this cycle.
- `din` in WIDTH: input word.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `and_o` out 1: AND of all frame bits.
- `or_o` out 1: OR of all frame bits.
- `xor_o` out 1: XOR of all frame bits (frame parity).
- `pop_o` out `$clog2(WIDTH*WORDS+1)`: number of ones in the frame. Present only with `REDUCE_STREAM_POPCNT_EN`.

## Operation
- States: ACC (collecting beats) and DONE (holding the result).
- Beat counter `cnt` counts 0..WORDS-1. Its width is `max(1,$clog2(WORDS))`.
- Accumulator seeds: `and_acc`=1, `or_acc`=0, `xor_acc`=0, `pop_acc`=0.
- A beat is accepted when `in_valid && in_ready`. In ACC on an accepted beat:
  - `and_acc &= &din`
  - `or_acc |= |din`
  - `xor_acc ^= ^din`
  - `pop_acc += popcount(din)`
  - `cnt++`
- Last beat is the accepted beat with `cnt==WORDS-1`:
  - Final values (including this beat) are loaded into `and_o`, `or_o`, `xor_o`, `pop_o`.
  - `out_valid` is set and the state goes to DONE.
  - Accumulators are reseeded and `cnt` returns to 0.
- `in_ready = ~out_valid`. `in_ready` is low throughout DONE.
- In DONE, when `out_valid && out_ready`: `out_valid` clears and the state returns to ACC. Result outputs keep their last values; they are don't-care while `out_valid`=0.
- `clear`=1 (in any state):
  - State goes to ACC, `cnt`=0, accumulators reseed, `out_valid`=0.
  - A beat presented in the same cycle is dropped.
  - A pending result is discarded.
- `clear` has priority over the beat and over the output handshake.
- `WORDS`=1: every accepted beat is a complete frame.
- Accumulation needs no modulo arithmetic: `pop_acc` width is sized so that all ones in a frame cannot overflow it.
- Reset (`rst_n`=0, at any time, including mid-frame or in DONE):
  - State ACC, `cnt`=0, accumulators at their seeds.
  - `out_valid`=0, `and_o`=0, `or_o`=0, `xor_o`=0, `pop_o`=0.
  - `in_ready` reads 1 once `out_valid` is 0.

## Timing
- Throughput: one beat per cycle in ACC.
- Latency: `out_valid` rises on the clock edge that accepts the last beat. It is observed the cycle after the last `din`.
- One bubble per frame: the earliest next beat is accepted in the cycle after the result handshake, because `in_ready` is low in the handshake cycle.
- Minimum frame period: WORDS+1 cycles with `out_ready` tied high.
- Outputs are registered. `in_ready` is a direct function of the `out_valid` register.
- `out_valid` and all result outputs are stable while `out_valid && !out_ready`.

## Configuration
- `REDUCE_STREAM_POPCNT_EN` defined: the `pop_acc` register and the `pop_o` port exist and behave as described above.
- `REDUCE_STREAM_POPCNT_EN` undefined: the `pop_acc` register and the `pop_o` port are removed. All other behaviour and timing are identical.

## Test plan
- Reset, WIDTH=4, WORDS=4, `out_ready`=1; beats 0xF,0xF,0xF,0xF on consecutive cycles -> one cycle later `out_valid`=1, `and_o`=1, `or_o`=1, `xor_o`=0, `pop_o`=16; next beat accepted 2 cycles after the last beat.
- Beats 0x1,0x0,0x0,0x0 -> `and_o`=0, `or_o`=1, `xor_o`=1, `pop_o`=1.
- After a frame of 0x7,0x7,0x7,0x7, hold `out_ready`=0 for 5 cycles with `in_valid`=1 -> `in_ready`=0, no beat consumed, outputs stable at `and_o`=0, `or_o`=1, `xor_o`=0, `pop_o`=12; raise `out_ready` -> `out_valid` falls next edge, `in_ready`=1.
- Two beats of 0xF, then `clear`=1 together with a third beat, then four beats of 0x0 -> a single result with `and_o`=0, `or_o`=0, `xor_o`=0, `pop_o`=0; no result produced for the aborted frame.
- Assert `rst_n`=0 asynchronously mid-frame (after 3 beats) and also while in DONE -> all outputs 0 immediately, `in_ready`=1 after release; the next 4 beats form a complete fresh frame.
- WORDS=1, WIDTH=8: beat 0xA5 -> `and_o`=0, `or_o`=1, `xor_o`=0, `pop_o`=4.
